regbank_mux_rf: RTL and testbench
=================================

Name: regbank_mux_rf

Overview:
Parametrised register bank with NRD independent registered read ports and one write port. It is the next-generation replacement for the flat 16-to-1 word select used for register-file reads in the datapath. Additions over the flat select:
- generic width, depth and port count
- 1-cycle registered read with valid strobe
- write-to-read bypass
- optional hardwired zero register
- out-of-range address detection

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 16, number of registers; need not be a power of two (min 2)
NRD, 2, number of read ports (1..4)
ADDR_W, $clog2(DEPTH), address width; derived, not overridden
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes
BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  WIDTH  write data
rd_en  input  NRD  per-port read request
raddr  input  NRD*ADDR_W  read addresses; port p = bits [p*ADDR_W +: ADDR_W]
rdata  output  NRD*WIDTH  registered read data; port p = bits [p*WIDTH +: WIDTH]
rvalid  output  NRD  per-port 1-cycle pulse, high when rdata[p] holds a new result
addr_err  output  NRD  per-port flag, high with rvalid when the request address was >= DEPTH

Behaviour:
- Reset: on a clk edge with rst=1, all registers, all rdata, rvalid and addr_err go to 0. rst overrides we and rd_en in the same cycle; no write is committed.
- Write: at a clk edge with we=1, rst=0 and waddr<DEPTH, reg[waddr] <= wdata. The write is ignored (no error flag) in two cases:
  - waddr >= DEPTH
  - ZERO_REG=1 and waddr=0
- Read latency is 1 cycle. If rd_en[p]=1 in cycle N, then in cycle N+1 rvalid[p]=1 and rdata[p]=value, where value is taken in this priority:
  1. raddr >= DEPTH -> 0, and addr_err[p]=1
  2. ZERO_REG=1 and raddr=0 -> 0
  3. BYPASS=1, we=1 and waddr=raddr (valid, nonzero-if-ZERO_REG) -> wdata
  4. otherwise -> reg[raddr] as held before the edge
- With BYPASS=0, a same-cycle read of the written address returns the old value. The new value is visible from the next request.
- rd_en[p]=0: in the next cycle rvalid[p]=0 and addr_err[p]=0; rdata[p] holds its last value.
- Ports are fully independent:
  - any ports may read the same address in the same cycle
  - no arbitration or stalls
  - rd_en is honoured every cycle, so back-to-back reads give back-to-back rvalid.
- addr_err is only asserted together with rvalid.
- Read selection is combinational from raddr into the output register; there is no pipelining beyond that register.

Decomposition:
- Package rf_pkg holds:
  - default constants RF_WIDTH=32, RF_DEPTH=16, RF_NRD=2
  - a function computing ADDR_W for DEPTH>=2
- Sub-module rf_read_port implements one port: select, bypass compare, zero/out-of-range handling, output register and rvalid/addr_err flops. It is instantiated NRD times in a generate loop.
- The storage array and write logic stay in regbank_mux_rf.

Test Plan:
1. Reset: rst=1 for 2 cycles with we=1, waddr=3, wdata=0xDEADBEEF -> rdata=0, rvalid=0, addr_err=0. A subsequent read of addr 3 returns 0.
2. Write then read: we at addr 5 with 0x12345678; next cycle rd_en[0]=1, raddr0=5 -> one cycle later rdata0=0x12345678, rvalid[0]=1; the following cycle rvalid[0]=0 and rdata0 holds.
3. Bypass: reg7=0x11111111. Same cycle we addr 7 with 0x22222222, rd_en[1]=1, raddr1=7:
   - BYPASS=1 -> rdata1=0x22222222
   - BYPASS=0 -> 0x11111111, then 0x22222222 on the next read
4. Zero register (ZERO_REG=1): write 0xFFFFFFFF to addr 0 with a same-cycle read of addr 0 on both ports -> rdata0=rdata1=0, and later reads also give 0. With ZERO_REG=0, the later read gives 0xFFFFFFFF.
5. Out-of-range (DEPTH=12, ADDR_W=4):
   - write addr 13 -> no register changes
   - read addr 13 -> rdata=0, rvalid=1, addr_err=1
   - read addr 11 -> addr_err=0
6. Reset mid-operation: back-to-back reads on both ports of addrs 2/4 (0xA, 0xB), rst asserted in the third request cycle -> next cycle all outputs 0, storage cleared, and a read after rst deasserts returns 0.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants, read-source encoding and address-width helper for the register bank
package rf_pkg;

   localparam int RF_WIDTH = 32;
   localparam int RF_DEPTH = 16;
   localparam int RF_NRD   = 2;

   typedef enum logic [1:0] {
      SRC_REG    = 2'd0,
      SRC_ZERO   = 2'd1,
      SRC_BYPASS = 2'd2,
      SRC_OOR    = 2'd3
   } rf_src_e;

   // Address width for a bank of depth >= 2 registers.
   function automatic int rf_addr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one registered read port: select, bypass, zero and out-of-range handling
module rf_read_port
   import rf_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int DEPTH    = RF_DEPTH,
   parameter int ADDR_W   = rf_addr_w(RF_DEPTH),
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rd_en,
   input  logic [ADDR_W-1:0]            raddr,
   input  logic                         we,
   input  logic [ADDR_W-1:0]            waddr,
   input  logic [WIDTH-1:0]             wdata,
   input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
   output logic [WIDTH-1:0]             rdata,
   output logic                         rvalid,
   output logic                         addr_err
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   rf_src_e          src;
   logic [WIDTH-1:0] reg_word;
   logic [WIDTH-1:0] sel_data;

   // Decoded mux rather than regs[raddr] so non-power-of-two depths never index past the array.
   always_comb begin
      reg_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (raddr == ADDR_W'(i)) begin
            reg_word = regs[i];
         end
      end
   end

   always_comb begin
      if ({1'b0, raddr} >= DEPTH_C) begin
         src = SRC_OOR;
      end else if (ZERO_REG && (raddr == '0)) begin
         src = SRC_ZERO;
      end else if (BYPASS && we && (waddr == raddr)) begin
         src = SRC_BYPASS;
      end else begin
         src = SRC_REG;
      end
   end

   always_comb begin
      sel_data = '0;
      case (src)
         SRC_BYPASS: sel_data = wdata;
         SRC_REG:    sel_data = reg_word;
         default:    sel_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata    <= '0;
         rvalid   <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         rvalid   <= rd_en;
         addr_err <= rd_en && (src == SRC_OOR);
         if (rd_en) begin
            rdata <= sel_data;
         end
      end
   end

endmodule

// File: rtl/regbank_mux_rf.sv
// rtl/regbank_mux_rf.sv - register bank with one write port and NRD independent registered read ports
module regbank_mux_rf
   import rf_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int DEPTH    = RF_DEPTH,
   parameter int NRD      = RF_NRD,
   parameter int ADDR_W   = rf_addr_w(DEPTH),
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       waddr,
   input  logic [WIDTH-1:0]        wdata,
   input  logic [NRD-1:0]          rd_en,
   input  logic [NRD*ADDR_W-1:0]   raddr,
   output logic [NRD*WIDTH-1:0]    rdata,
   output logic [NRD-1:0]          rvalid,
   output logic [NRD-1:0]          addr_err
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] regs;
   logic                        wr_ok;

   // Out-of-range and zero-register writes are dropped silently.
   assign wr_ok = we && ({1'b0, waddr} < DEPTH_C) && !(ZERO_REG && (waddr == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         regs <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && (waddr == ADDR_W'(i))) begin
               regs[i] <= wdata;
            end
         end
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      rf_read_port #(
         .WIDTH    (WIDTH),
         .DEPTH    (DEPTH),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_port (
         .clk      (clk),
         .rst      (rst),
         .rd_en    (rd_en[p]),
         .raddr    (raddr[p*ADDR_W +: ADDR_W]),
         .we       (we),
         .waddr    (waddr),
         .wdata    (wdata),
         .regs     (regs),
         .rdata    (rdata[p*WIDTH +: WIDTH]),
         .rvalid   (rvalid[p]),
         .addr_err (addr_err[p])
      );
   end

endmodule

// File: tb/tb_regbank_mux_rf.sv
// tb/tb_regbank_mux_rf.sv - directed bench: default bank (a) and a 12-deep, no-zero, no-bypass bank (b)
module tb_regbank_mux_rf;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [3:0]  waddr;
   logic [31:0] wdata;
   logic [1:0]  rd_en;
   logic [7:0]  raddr;

   logic [63:0] a_rdata, b_rdata;
   logic [1:0]  a_rvalid, b_rvalid;
   logic [1:0]  a_err, b_err;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_b [12];

   always #5 clk = ~clk;

   regbank_mux_rf dut_a (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .rd_en(rd_en), .raddr(raddr),
      .rdata(a_rdata), .rvalid(a_rvalid), .addr_err(a_err)
   );

   regbank_mux_rf #(.WIDTH(32), .DEPTH(12), .NRD(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .rd_en(rd_en), .raddr(raddr),
      .rdata(b_rdata), .rvalid(b_rvalid), .addr_err(b_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] en, input logic [3:0] a0, input logic [3:0] a1);
      rd_en = en;
      raddr = {a1, a0};
   endtask

   initial begin
      rst = 1'b1; we = 1'b1; waddr = 4'd3; wdata = 32'hDEADBEEF;
      rd(2'b00, 4'd0, 4'd0);
      step(); step();
      chk("rst_a_rdata", a_rdata[31:0] | a_rdata[63:32], 32'h0);
      chk("rst_a_rvalid", {30'd0, a_rvalid}, 32'h0);
      chk("rst_a_err", {30'd0, a_err}, 32'h0);
      chk("rst_b_rvalid", {30'd0, b_rvalid}, 32'h0);

      rst = 1'b0; we = 1'b0;
      rd(2'b01, 4'd3, 4'd0);
      step();
      chk("rst_a_read3", a_rdata[31:0], 32'h0);
      chk("rst_a_rv", {30'd0, a_rvalid}, 32'h1);
      chk("rst_b_read3", b_rdata[31:0], 32'h0);

      // write then read
      rd(2'b00, 4'd0, 4'd0);
      we = 1'b1; waddr = 4'd5; wdata = 32'h12345678;
      step();
      we = 1'b0;
      rd(2'b01, 4'd5, 4'd0);
      step();
      chk("wr_a_rdata0", a_rdata[31:0], 32'h12345678);
      chk("wr_a_rv", {30'd0, a_rvalid}, 32'h1);
      chk("wr_b_rdata0", b_rdata[31:0], 32'h12345678);
      rd(2'b00, 4'd5, 4'd0);
      step();
      chk("wr_a_rv_drop", {30'd0, a_rvalid}, 32'h0);
      chk("wr_a_hold", a_rdata[31:0], 32'h12345678);

      // bypass
      we = 1'b1; waddr = 4'd7; wdata = 32'h11111111;
      step();
      wdata = 32'h22222222;
      rd(2'b10, 4'd0, 4'd7);
      step();
      chk("byp_a_rdata1", a_rdata[63:32], 32'h22222222);
      chk("byp_b_rdata1", b_rdata[63:32], 32'h11111111);
      chk("byp_a_rv", {30'd0, a_rvalid}, 32'h2);
      we = 1'b0;
      step();
      chk("byp_b_next", b_rdata[63:32], 32'h22222222);

      // zero register
      we = 1'b1; waddr = 4'd0; wdata = 32'hFFFFFFFF;
      rd(2'b11, 4'd0, 4'd0);
      step();
      chk("zr_a_rdata0", a_rdata[31:0], 32'h0);
      chk("zr_a_rdata1", a_rdata[63:32], 32'h0);
      chk("zr_b_rdata0", b_rdata[31:0], 32'h0);
      we = 1'b0;
      step();
      chk("zr_a_later", a_rdata[31:0] | a_rdata[63:32], 32'h0);
      chk("zr_b_later", b_rdata[31:0], 32'hFFFFFFFF);

      // out of range on the 12-deep bank
      rd(2'b00, 4'd0, 4'd0);
      we = 1'b1; waddr = 4'd13; wdata = 32'h55555555;
      step();
      we = 1'b0;
      rd(2'b11, 4'd13, 4'd11);
      step();
      chk("oor_b_rdata0", b_rdata[31:0], 32'h0);
      chk("oor_b_rv", {30'd0, b_rvalid}, 32'h3);
      chk("oor_b_err", {30'd0, b_err}, 32'h1);
      chk("oor_b_rdata1", b_rdata[63:32], 32'h0);
      chk("oor_a_rdata0", a_rdata[31:0], 32'h55555555);
      chk("oor_a_err", {30'd0, a_err}, 32'h0);
      rd(2'b00, 4'd13, 4'd11);
      step();
      chk("oor_b_err_clr", {30'd0, b_err}, 32'h0);

      for (int i = 0; i < 12; i++) exp_b[i] = 32'h0;
      exp_b[0] = 32'hFFFFFFFF;
      exp_b[5] = 32'h12345678;
      exp_b[7] = 32'h22222222;
      for (int i = 0; i < 12; i++) begin
         rd(2'b01, 4'(i), 4'd0);
         step();
         chk($sformatf("scan_b_%0d", i), b_rdata[31:0], exp_b[i]);
      end

      // reset in the middle of back-to-back reads
      rd(2'b00, 4'd0, 4'd0);
      we = 1'b1; waddr = 4'd2; wdata = 32'h0000000A;
      step();
      waddr = 4'd4; wdata = 32'h0000000B;
      step();
      we = 1'b0;
      rd(2'b11, 4'd2, 4'd4);
      step();
      chk("b2b1_a", {a_rdata[35:32], a_rdata[3:0]}, 32'hBA);
      chk("b2b1_a_rv", {30'd0, a_rvalid}, 32'h3);
      step();
      chk("b2b2_b", {b_rdata[35:32], b_rdata[3:0]}, 32'hBA);
      chk("b2b2_a_rv", {30'd0, a_rvalid}, 32'h3);
      rst = 1'b1;
      step();
      chk("mid_a_rdata", a_rdata[31:0] | a_rdata[63:32], 32'h0);
      chk("mid_a_rv", {30'd0, a_rvalid}, 32'h0);
      chk("mid_b_rdata", b_rdata[31:0] | b_rdata[63:32], 32'h0);
      rst = 1'b0;
      step();
      chk("post_a_rdata", a_rdata[31:0] | a_rdata[63:32], 32'h0);
      chk("post_a_rv", {30'd0, a_rvalid}, 32'h3);
      chk("post_b_rdata", b_rdata[31:0] | b_rdata[63:32], 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
